// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR execute unit: addresses, field
// positions, WARL write masks and the misa value for a given XLEN.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIP_MSIP       = 3;
  localparam int MIP_MTIP       = 7;
  localparam int MIP_MEIP       = 11;

  localparam logic [63:0] MIE_WMASK   = 64'h888;
  localparam logic [63:0] MTVEC_WMASK = ~64'h2;
  localparam logic [63:0] MEPC_WMASK  = ~64'h3;

  // MXL sits in the top two bits of the XLEN-wide register; only base I is reported.
  function automatic logic [63:0] misa_value(int xlen);
    logic [63:0] v;
    v = 64'h100;
    if (xlen == 32) v[31:30] = 2'b01;
    else            v[63:62] = 2'b10;
    return v;
  endfunction

endpackage

// File: rtl/csr_op_alu.sv
// Combinational CSRRW/CSRRS/CSRRC new-value computation and write-suppress
// decision, shared by every CSR in the unit.
module csr_op_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            op_rw,
  input  logic            op_rs,
  input  logic            op_rc,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] new_val,
  output logic            wr_req
);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    new_val = old_val;
    if (op_rw)      new_val = operand;
    else if (op_rs) new_val = old_val | operand;
    else if (op_rc) new_val = old_val & ~operand;
  end

  // Set/clear with a zero mask is a pure read and must not count as a write.
  assign wr_req = op_rw | ((op_rs | op_rc) & (|operand));

endmodule

// File: rtl/csr_exe_unit.sv
// Machine-mode CSR execute unit with registered writeback, WARL masking and
// trap/mret updates. Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_exe_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RB     = 3,
  parameter int HARTID = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              beFlush,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic              op_rw,
  input  logic              op_rs,
  input  logic              op_rc,
  input  logic [5+RB-1:0]   rd0,
  input  logic [XLEN-1:0]   op,
  input  logic [11:0]       addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_res,
  output logic [5+RB-1:0]   wb_rd0,
  output logic              wb_illegal,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_epc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic              mret_valid,
  input  logic              irq_mtip,
  input  logic              irq_meip,
  input  logic              instret_inc,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic              mstatus_mie_o
);

  localparam logic [XLEN-1:0] MISA = XLEN'(misa_value(XLEN));

  logic            st_mie, st_mpie, msip;
  logic [XLEN-1:0] mie_q, mtvec, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] mstatus_rd, mip_rd, rd_val, new_val, res_val;
  logic            hit, ro, wr_req, illegal, accept, wr_fire;

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle, minstret;
`else
  logic unused_instret_inc;
  assign unused_instret_inc = instret_inc;
`endif

  assign exe_ready = ~wb_valid | wb_ready;
  assign accept    = exe_valid & exe_ready & ~beFlush;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]                     = st_mie;
    mstatus_rd[MSTATUS_MPIE]                    = st_mpie;
    mstatus_rd[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
    mip_rd = '0;
    mip_rd[MIP_MSIP] = msip;
    mip_rd[MIP_MTIP] = irq_mtip;
    mip_rd[MIP_MEIP] = irq_meip;
  end

  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    ro     = 1'b0;
    case (addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: ro = 1'b1;
      CSR_MHARTID:  begin ro = 1'b1; rd_val = XLEN'(HARTID); end
      CSR_MSTATUS:  rd_val = mstatus_rd;
      CSR_MISA:     rd_val = MISA;
      CSR_MIE:      rd_val = mie_q;
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MSCRATCH: rd_val = mscratch;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
      CSR_MTVAL:    rd_val = mtval;
      CSR_MIP:      rd_val = mip_rd;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rd_val = mcycle;
      CSR_MINSTRET: rd_val = minstret;
      CSR_CYCLE:    begin ro = 1'b1; rd_val = mcycle;   end
      CSR_INSTRET:  begin ro = 1'b1; rd_val = minstret; end
`endif
      default:      hit = 1'b0;
    endcase
  end

  csr_op_alu #(.XLEN(XLEN)) u_alu (
    .op_rw   (op_rw),
    .op_rs   (op_rs),
    .op_rc   (op_rc),
    .old_val (rd_val),
    .operand (op),
    .new_val (new_val),
    .wr_req  (wr_req)
  );

  assign illegal = ~hit | (ro & wr_req);
  assign wr_fire = accept & wr_req & ~illegal;
  assign res_val = (illegal | (op_rw & (rd0 == '0))) ? '0 : rd_val;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid   <= 1'b0;
      wb_res     <= '0;
      wb_rd0     <= '0;
      wb_illegal <= 1'b0;
    end else if (beFlush) begin
      wb_valid <= 1'b0;
    end else if (accept) begin
      wb_valid   <= 1'b1;
      wb_res     <= res_val;
      wb_rd0     <= rd0;
      wb_illegal <= illegal;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // Trap beats mret beats a CSR write to any register the event itself updates.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_mie <= 1'b0;  st_mpie <= 1'b0;  msip <= 1'b0;
      mie_q  <= '0;    mtvec   <= '0;    mscratch <= '0;
      mepc   <= '0;    mcause  <= '0;    mtval    <= '0;
    end else begin
      if (trap_valid) begin
        mepc    <= trap_epc & XLEN'(MEPC_WMASK);
        mcause  <= trap_cause;
        mtval   <= trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else begin
        if (mret_valid) begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
        end else if (wr_fire && addr == CSR_MSTATUS) begin
          st_mie  <= new_val[MSTATUS_MIE];
          st_mpie <= new_val[MSTATUS_MPIE];
        end
        if (wr_fire && addr == CSR_MEPC)   mepc   <= new_val & XLEN'(MEPC_WMASK);
        if (wr_fire && addr == CSR_MCAUSE) mcause <= new_val;
        if (wr_fire && addr == CSR_MTVAL)  mtval  <= new_val;
      end
      if (wr_fire && addr == CSR_MIE)      mie_q    <= new_val & XLEN'(MIE_WMASK);
      if (wr_fire && addr == CSR_MTVEC)    mtvec    <= new_val & XLEN'(MTVEC_WMASK);
      if (wr_fire && addr == CSR_MSCRATCH) mscratch <= new_val;
      if (wr_fire && addr == CSR_MIP)      msip     <= new_val[MIP_MSIP];
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= (wr_fire && addr == CSR_MCYCLE)   ? new_val : mcycle + XLEN'(1);
      minstret <= (wr_fire && addr == CSR_MINSTRET) ? new_val : minstret + XLEN'(instret_inc);
    end
  end
`endif

  assign mtvec_o       = mtvec;
  assign mepc_o        = mepc;
  assign mstatus_mie_o = st_mie;

endmodule

// File: tb/tb_csr_exe_unit.sv
// Self-checking bench for csr_exe_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_csr_exe_unit;

  localparam int XLEN   = 64;
  localparam int RB     = 3;
  localparam int TW     = 5 + RB;
  localparam int HARTID = 7;
  localparam logic [63:0] MISA64 = 64'h8000_0000_0000_0100;

  logic            CLK = 1'b0;
  logic            RST;
  logic            beFlush, exe_valid, exe_ready, op_rw, op_rs, op_rc;
  logic [TW-1:0]   rd0, wb_rd0;
  logic [XLEN-1:0] op, wb_res, trap_cause, trap_epc, trap_tval, mtvec_o, mepc_o;
  logic [11:0]     addr;
  logic            wb_valid, wb_ready, wb_illegal, trap_valid, mret_valid;
  logic            irq_mtip, irq_meip, instret_inc, mstatus_mie_o;

  always #5 CLK = ~CLK;

  csr_exe_unit #(.XLEN(XLEN), .RB(RB), .HARTID(HARTID)) dut (
    .CLK(CLK), .RST(RST), .beFlush(beFlush), .exe_valid(exe_valid), .exe_ready(exe_ready),
    .op_rw(op_rw), .op_rs(op_rs), .op_rc(op_rc), .rd0(rd0), .op(op), .addr(addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_res(wb_res), .wb_rd0(wb_rd0),
    .wb_illegal(wb_illegal), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .irq_mtip(irq_mtip), .irq_meip(irq_meip), .instret_inc(instret_inc),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_mie_o(mstatus_mie_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          v, rw, rs, rc, wbr, flush, trap, mret, mtip, meip, inc;
    logic [11:0] a;
    logic [63:0] d, cause, epc, tval;
    logic [7:0]  rd;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          e_ill;
    logic [63:0] e_res;
    bit          e_mie;
  } vec_t;

  // Reference model: architectural CSR contents plus the expected writeback slot.
  bit          m_st_mie, m_st_mpie, m_msip, m_wbv, m_wbill;
  logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret, m_wbres;
  logic [7:0]  m_wbrd;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.wbr = 1'b1;
    return s;
  endfunction

  function automatic stim_t csr(int kind, logic [11:0] a, logic [63:0] d, logic [7:0] rd);
    stim_t s;
    s = idle();
    s.v = 1'b1; s.rw = (kind == 0); s.rs = (kind == 1); s.rc = (kind == 2);
    s.a = a; s.d = d; s.rd = rd;
    return s;
  endfunction

  function automatic void model_read(input logic [11:0] a, input bit mtip, input bit meip,
                                     output bit ok, output bit ro, output logic [63:0] v);
    ok = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
      12'hF14: begin ro = 1'b1; v = 64'(HARTID); end
      12'h300: v = 64'h1800 | (m_st_mie ? 64'h8 : 64'h0) | (m_st_mpie ? 64'h80 : 64'h0);
      12'h301: v = MISA64;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (m_msip ? 64'h8 : 64'h0) | (mtip ? 64'h80 : 64'h0) | (meip ? 64'h800 : 64'h0);
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_mcycle;
      12'hB02: v = m_minstret;
      12'hC00: begin ro = 1'b1; v = m_mcycle;   end
      12'hC02: begin ro = 1'b1; v = m_minstret; end
`endif
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic model_step(stim_t s);
    bit ok, ro, wr, ill, acc, drop, pmie, pmpie;
    logic [63:0] old, nv;
    acc = s.v && (!m_wbv || s.wbr) && !s.flush;
    model_read(s.a, s.mtip, s.meip, ok, ro, old);
    wr  = s.rw || ((s.rs || s.rc) && s.d != 0);
    ill = !ok || (ro && wr);
    nv  = s.rw ? s.d : s.rs ? (old | s.d) : (old & ~s.d);
    if (s.flush) m_wbv = 1'b0;
    else if (acc) begin
      m_wbv = 1'b1; m_wbill = ill; m_wbrd = s.rd;
      m_wbres = (ill || (s.rw && s.rd == 0)) ? 64'h0 : old;
    end else if (s.wbr) m_wbv = 1'b0;
    pmie = m_st_mie; pmpie = m_st_mpie;
    m_mcycle   = m_mcycle + 1;
    m_minstret = m_minstret + 64'(s.inc);
    drop = (s.trap && (s.a inside {12'h300, 12'h341, 12'h342, 12'h343})) ||
           (s.mret && s.a == 12'h300);
    if (acc && wr && !ill && !drop) begin
      case (s.a)
        12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
        12'h304: m_mie = nv & 64'h888;
        12'h305: m_mtvec = nv & ~64'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~64'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'h344: m_msip = nv[3];
        12'hB00: m_mcycle = nv;
        12'hB02: m_minstret = nv;
        default: ;
      endcase
    end
    if (s.trap) begin
      m_mepc = s.epc & ~64'h3; m_mcause = s.cause; m_mtval = s.tval;
      m_st_mpie = pmie; m_st_mie = 1'b0;
    end else if (s.mret) begin
      m_st_mie = pmpie; m_st_mpie = 1'b1;
    end
  endtask

  task automatic step(stim_t s);
    @(negedge CLK);
    exe_valid = s.v; op_rw = s.rw; op_rs = s.rs; op_rc = s.rc; addr = s.a; op = s.d;
    rd0 = s.rd; wb_ready = s.wbr; beFlush = s.flush; trap_valid = s.trap;
    mret_valid = s.mret; trap_cause = s.cause; trap_epc = s.epc; trap_tval = s.tval;
    irq_mtip = s.mtip; irq_meip = s.meip; instret_inc = s.inc;
    #1;
    check("exe_ready", exe_ready, !m_wbv || s.wbr);
    @(posedge CLK);
    model_step(s);
    #1;
    check("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      check("wb_res", wb_res, m_wbres);
      check("wb_rd0", wb_rd0, m_wbrd);
      check("wb_illegal", wb_illegal, m_wbill);
    end
    check("mtvec_o", mtvec_o, m_mtvec);
    check("mepc_o", mepc_o, m_mepc);
    check("mstatus_mie_o", mstatus_mie_o, m_st_mie);
  endtask

  vec_t tbl[$];

  task automatic add(stim_t s, bit ill, logic [63:0] res, bit mie);
    vec_t v;
    v.s = s; v.e_ill = ill; v.e_res = res; v.e_mie = mie;
    tbl.push_back(v);
  endtask

  logic [11:0] addr_list [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hF11, 12'hF14, 12'hB00,
                                   12'hB02, 12'hC00, 12'hC02, 12'h7C0};

  initial begin
    stim_t s;
    RST = 1'b1;
    {beFlush, exe_valid, op_rw, op_rs, op_rc, trap_valid, mret_valid} = '0;
    {irq_mtip, irq_meip, instret_inc} = '0;
    rd0 = '0; op = '0; addr = '0; trap_cause = '0; trap_epc = '0; trap_tval = '0;
    wb_ready = 1'b1;
    {m_st_mie, m_st_mpie, m_msip, m_wbv, m_wbill} = '0;
    {m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret, m_wbres} = '0;
    m_wbrd = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_res", wb_res, 0);
    check("rst_wb_rd0", wb_rd0, 0);
    check("rst_wb_illegal", wb_illegal, 0);
    check("rst_mtvec", mtvec_o, 0);
    check("rst_mie", mstatus_mie_o, 0);
    check("rst_exe_ready", exe_ready, 1);
    @(negedge CLK);
    RST = 1'b0;

    add(csr(0, 12'h305, 64'h1003, 8'd5),  0, 64'h0, 0);
    add(csr(1, 12'h305, 64'h0, 8'd1),     0, 64'h1001, 0);
    add(csr(1, 12'h300, 64'h8, 8'd2),     0, 64'h1800, 1);
    add(csr(2, 12'h300, 64'h8, 8'd3),     0, 64'h1808, 0);
    add(csr(0, 12'hF11, 64'h1, 8'd4),     1, 64'h0, 0);
    add(csr(1, 12'hF14, 64'h0, 8'd6),     0, 64'(HARTID), 0);
    add(csr(1, 12'h301, 64'h0, 8'd7),     0, MISA64, 0);
    add(csr(0, 12'h301, 64'hFF, 8'd8),    0, MISA64, 0);
    add(csr(1, 12'h301, 64'h0, 8'd9),     0, MISA64, 0);
    add(csr(0, 12'h304, '1, 8'd10),       0, 64'h0, 0);
    add(csr(2, 12'h304, 64'h0, 8'd11),    0, 64'h888, 0);
    add(csr(0, 12'h341, 64'h1237, 8'd0),  0, 64'h0, 0);
    add(csr(1, 12'h341, 64'h0, 8'd12),    0, 64'h1234, 0);
    s = csr(0, 12'h344, 64'hFFF, 8'd13); s.mtip = 1'b1;
    add(s, 0, 64'h80, 0);
    s = csr(1, 12'h344, 64'h0, 8'd14); s.meip = 1'b1;
    add(s, 0, 64'h808, 0);
    add(csr(1, 12'h7C0, 64'h0, 8'd15),    1, 64'h0, 0);
    add(csr(2, 12'hF12, 64'h0, 8'd16),    0, 64'h0, 0);
    add(csr(0, 12'h340, 64'hDEADBEEF, 8'd17), 0, 64'h0, 0);
    add(csr(1, 12'h340, 64'h0, 8'd18),    0, 64'hDEADBEEF, 0);

    foreach (tbl[i]) begin
      step(tbl[i].s);
      check($sformatf("vec%0d_valid", i), wb_valid, 1);
      check($sformatf("vec%0d_res", i), wb_res, tbl[i].e_res);
      check($sformatf("vec%0d_rd0", i), wb_rd0, tbl[i].s.rd);
      check($sformatf("vec%0d_illegal", i), wb_illegal, tbl[i].e_ill);
      check($sformatf("vec%0d_mie", i), mstatus_mie_o, tbl[i].e_mie);
    end

    // Backpressure: result held three cycles while a second op waits.
    step(idle());
    s = csr(1, 12'h340, 64'h0, 8'd20); s.wbr = 1'b0;
    step(s);
    s = csr(1, 12'h305, 64'h0, 8'd21); s.wbr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(s);
      check("hold_ready", exe_ready, 0);
      check("hold_res", wb_res, 64'hDEADBEEF);
      check("hold_rd0", wb_rd0, 20);
    end
    s.wbr = 1'b1;
    step(s);
    check("release_rd0", wb_rd0, 21);
    check("release_res", wb_res, 64'h1001);

    // Flush blocks acceptance and any write; flush also drops a held result.
    s = csr(0, 12'h340, 64'h55, 8'd22); s.flush = 1'b1;
    step(s);
    check("flush_valid", wb_valid, 0);
    step(csr(1, 12'h340, 64'h0, 8'd23));
    check("flush_nowrite", wb_res, 64'hDEADBEEF);
    s = idle(); s.wbr = 1'b0; s.flush = 1'b1;
    step(s);
    check("flush_held", wb_valid, 0);

    // Trap with same-cycle write to mepc, then mret.
    step(csr(1, 12'h300, 64'h8, 8'd24));
    s = csr(0, 12'h341, 64'h5555, 8'd25);
    s.trap = 1'b1; s.epc = 64'h8000_0006; s.cause = 64'hB; s.tval = 64'h77;
    step(s);
    check("trap_mepc", mepc_o, 64'h8000_0004);
    check("trap_mie", mstatus_mie_o, 0);
    check("trap_old", wb_res, 64'h1234);
    step(csr(1, 12'h300, 64'h0, 8'd26));
    check("trap_mstatus", wb_res, 64'h1880);
    step(csr(1, 12'h342, 64'h0, 8'd27));
    check("trap_mcause", wb_res, 64'hB);
    s = idle(); s.mret = 1'b1;
    step(s);
    check("mret_mie", mstatus_mie_o, 1);
    step(csr(1, 12'h300, 64'h0, 8'd28));
    check("mret_mstatus", wb_res, 64'h1888);
    s = idle(); s.trap = 1'b1; s.mret = 1'b1; s.epc = 64'h40;
    step(s);
    check("trap_over_mret", mstatus_mie_o, 0);

`ifdef CSR_COUNTERS_EN
    step(csr(0, 12'hB00, '1, 8'd29));
    step(idle());
    step(idle());
    step(csr(1, 12'hB00, 64'h0, 8'd30));
    check("mcycle_wrap", wb_res, 64'h1);
    step(csr(0, 12'hC00, 64'h3, 8'd31));
    check("cycle_ro", wb_illegal, 1);
`else
    step(csr(1, 12'hB00, 64'h0, 8'd29));
    check("mcycle_absent", wb_illegal, 1);
    check("mcycle_absent_res", wb_res, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      int k;
      s = idle();
      k = int'($urandom_range(0, 2));
      s.v = ($urandom_range(0, 3) != 0);
      s.rw = (k == 0); s.rs = (k == 1); s.rc = (k == 2);
      s.a = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addr_list[$urandom_range(0, 15)];
      s.d = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      s.rd = 8'($urandom);
      s.wbr = ($urandom_range(0, 3) != 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.trap = ($urandom_range(0, 15) == 0);
      s.mret = ($urandom_range(0, 15) == 0);
      s.cause = {$urandom, $urandom}; s.epc = {$urandom, $urandom}; s.tval = {$urandom, $urandom};
      s.mtip = 1'($urandom); s.meip = 1'($urandom); s.inc = 1'($urandom);
      step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
